// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage types: M-extension op encodings and the
// multiply/divide unit state machine encoding.
package riscv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic op_is_rem(input muldiv_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // rs1 is treated as signed by everything except the fully unsigned ops
    function automatic logic op1_signed(input muldiv_op_e op);
        return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    endfunction

    function automatic logic op2_signed(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, BITS_PER_CYCLE radix-2 steps per clock.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_1,
    input  logic [XLEN-1:0] operand_2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST_STEP = CW'(N - 1);
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state;
    muldiv_op_e        op;
    logic              neg_res;
    logic              neg_rem;
    logic [XLEN-1:0]   mag_a;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     rem;
    logic [CW-1:0]     count;

    muldiv_op_e      op_in;
    logic            sign_1;
    logic            sign_2;
    logic [XLEN-1:0] abs_1;
    logic [XLEN-1:0] abs_2;
    logic            div_zero;
    logic            div_ovf;
    logic            fast;
    logic [XLEN-1:0] fast_result;

    assign op_in = muldiv_op_e'(funct3);

    // NOTE: every variable written in an always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        sign_1   = op1_signed(op_in) & operand_1[XLEN-1];
        sign_2   = op2_signed(op_in) & operand_2[XLEN-1];
        abs_1    = sign_1 ? -operand_1 : operand_1;
        abs_2    = sign_2 ? -operand_2 : operand_2;
        div_zero = (operand_2 == '0);
        div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (operand_1 == MIN_NEG) && (operand_2 == '1);
        fast     = op_is_div(op_in) && (div_zero || div_ovf);
        if (div_zero) begin
            fast_result = op_is_rem(op_in) ? operand_1 : '1;
        end else begin
            fast_result = op_is_rem(op_in) ? '0 : operand_1;
        end
    end

    // Unrolled radix-2 steps: multiply adds the multiplicand into the high half
    // and shifts right; divide shifts a quotient bit into the partial remainder.
    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_stage
        logic [2*XLEN-1:0] mul_in;
        logic [2*XLEN-1:0] mul_out;
        logic [XLEN:0]     sum;
        logic [XLEN:0]     rem_in;
        logic [XLEN:0]     rem_out;
        logic [XLEN+1:0]   shifted;
        logic [XLEN+1:0]   diff;
        logic [XLEN-1:0]   quo_in;
        logic [XLEN-1:0]   quo_out;

        if (g == 0) begin : g_first
            assign mul_in = prod;
            assign rem_in = rem;
            assign quo_in = prod[XLEN-1:0];
        end else begin : g_next
            assign mul_in = g_stage[g-1].mul_out;
            assign rem_in = g_stage[g-1].rem_out;
            assign quo_in = g_stage[g-1].quo_out;
        end

        assign sum     = {1'b0, mul_in[2*XLEN-1:XLEN]} +
                         (mul_in[0] ? {1'b0, mag_a} : {(XLEN+1){1'b0}});
        assign mul_out = {sum, mul_in[XLEN-1:1]};

        assign shifted = {rem_in, quo_in[XLEN-1]};
        assign diff    = shifted - {2'b00, mag_a};
        assign rem_out = diff[XLEN+1] ? shifted[XLEN:0] : diff[XLEN:0];
        assign quo_out = {quo_in[XLEN-2:0], ~diff[XLEN+1]};
    end

    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_next;
    logic [XLEN-1:0]   quo_next;

    assign mul_next = g_stage[BITS_PER_CYCLE-1].mul_out;
    assign rem_next = g_stage[BITS_PER_CYCLE-1].rem_out;
    assign quo_next = g_stage[BITS_PER_CYCLE-1].quo_out;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   sign_result;

    always_comb begin
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -prod[XLEN-1:0] : prod[XLEN-1:0];
        rem_fix  = neg_rem ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        case (op)
            OP_MUL:                       sign_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: sign_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              sign_result = quo_fix;
            default:                      sign_result = rem_fix;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= OP_MUL;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            mag_a     <= '0;
            prod      <= '0;
            rem       <= '0;
            count     <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op       <= op_in;
                        neg_res  <= sign_1 ^ sign_2;
                        neg_rem  <= sign_1;
                        mag_a    <= op_is_div(op_in) ? abs_2 : abs_1;
                        prod     <= {{XLEN{1'b0}}, (op_is_div(op_in) ? abs_1 : abs_2)};
                        rem      <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        if (fast) begin
                            result    <= fast_result;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_is_div(op)) begin
                        prod <= {prod[2*XLEN-1:XLEN], quo_next};
                        rem  <= rem_next;
                    end else begin
                        prod <= mul_next;
                    end
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    result    <= sign_result;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: four instances (32/1, 32/2, 32/4, 64/2)
// sharing operands, each with its own in_valid.
module tb_muldiv_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        out_ready;
    logic [2:0]  funct3;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [31:0] res0, res1, res2;
    logic [63:0] res3;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .funct3(funct3), .operand_1(op1[31:0]), .operand_2(op2[31:0]),
        .out_valid(out_valid[0]), .out_ready(out_ready), .result(res0));
    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(2)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .funct3(funct3), .operand_1(op1[31:0]), .operand_2(op2[31:0]),
        .out_valid(out_valid[1]), .out_ready(out_ready), .result(res1));
    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .funct3(funct3), .operand_1(op1[31:0]), .operand_2(op2[31:0]),
        .out_valid(out_valid[2]), .out_ready(out_ready), .result(res2));
    muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(2)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .funct3(funct3), .operand_1(op1), .operand_2(op2),
        .out_valid(out_valid[3]), .out_ready(out_ready), .result(res3));

    function automatic logic [63:0] res_of(input int k);
        case (k)
            0:       return {32'h0, res0};
            1:       return {32'h0, res1};
            2:       return {32'h0, res2};
            default: return res3;
        endcase
    endfunction

    // Normal-path latency N+1 for each instance
    function automatic int lat_of(input int k);
        case (k)
            0:       return 33;
            1:       return 17;
            2:       return 9;
            default: return 33;
        endcase
    endfunction

    function automatic logic [63:0] mask_of(input int k);
        return (k == 3) ? M1 : 64'h0000_0000_FFFF_FFFF;
    endfunction

    task automatic issue(input int k, input logic [2:0] fn, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        funct3      = fn;
        op1         = a;
        op2         = b;
        in_valid[k] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic run_op(input int k, input logic [2:0] fn, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_res,
                          input int exp_lat, input string name);
        int lat;
        issue(k, fn, a, b);
        lat = 0;
        while (!out_valid[k] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL %s dut%0d latency: got %0d want %0d", name, k, lat, exp_lat);
        end
        n_cmp++;
        if (res_of(k) !== (exp_res & mask_of(k))) begin
            n_bad++;
            $display("FAIL %s dut%0d result: got %h want %h", name, k, res_of(k), exp_res & mask_of(k));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s dut%0d drain: got ov=%b ir=%b want ov=0 ir=1", name, k, out_valid[k], in_ready[k]);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || res_of(k) !== 64'h0) begin
                n_bad++;
                $display("FAIL reset dut%0d: got ir=%b ov=%b res=%h want ir=1 ov=0 res=0",
                         k, in_ready[k], out_valid[k], res_of(k));
            end
        end
    endtask

    task automatic test_basic_ops(input int k);
        int l;
        l = lat_of(k);
        run_op(k, OP_MUL,    64'd7,  M1 - 64'd2, 64'hFFFF_FFFF_FFFF_FFEB, l, "mul_7x-3");
        run_op(k, OP_MULH,   64'd7,  M1 - 64'd2, M1,                      l, "mulh_7x-3");
        run_op(k, OP_MULHU,  M1,     M1,         64'hFFFF_FFFF_FFFF_FFFE, l, "mulhu_max");
        run_op(k, OP_MULHSU, M1,     M1,         M1,                      l, "mulhsu_-1");
        run_op(k, OP_DIV,    M1 - 64'd6, 64'd2,  M1 - 64'd2,              l, "div_-7/2");
        run_op(k, OP_REM,    M1 - 64'd6, 64'd2,  M1,                      l, "rem_-7/2");
        run_op(k, OP_DIVU,   64'd100, 64'd7,     64'd14,                  l, "divu_100/7");
        run_op(k, OP_REMU,   64'd100, 64'd7,     64'd2,                   l, "remu_100/7");
    endtask

    task automatic test_boundaries();
        run_op(0, OP_MULH, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 33, "mulh_min*min");
        run_op(0, OP_DIVU, 64'h8000_0000, M1, 64'h0,          33, "divu_min/max");
        run_op(0, OP_REMU, 64'h8000_0000, M1, 64'h8000_0000,  33, "remu_min/max");
        run_op(3, OP_DIVU, 64'h8000_0000_0000_0000, M1, 64'h0, 33, "divu64_min/max");
    endtask

    task automatic test_fast_path();
        run_op(0, OP_DIV,  64'd123, 64'd0, M1,      0, "div_by_0");
        run_op(0, OP_DIVU, 64'd123, 64'd0, M1,      0, "divu_by_0");
        run_op(0, OP_REM,  64'd5,   64'd0, 64'd5,   0, "rem_by_0");
        run_op(0, OP_REMU, 64'd9,   64'd0, 64'd9,   0, "remu_by_0");
        run_op(0, OP_DIV,  64'h8000_0000, M1, 64'h8000_0000, 0, "div_ovf");
        run_op(0, OP_REM,  64'h8000_0000, M1, 64'h0,         0, "rem_ovf");
        run_op(3, OP_DIV,  64'h8000_0000_0000_0000, M1, 64'h8000_0000_0000_0000, 0, "div64_ovf");
        run_op(3, OP_REM,  64'h8000_0000_0000_0000, M1, 64'h0,                   0, "rem64_ovf");
    endtask

    task automatic test_backpressure();
        int lat;
        issue(0, OP_MUL, 64'd6, 64'd7);
        lat = 0;
        while (!out_valid[0] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++;
        if (lat !== 33 || res0 !== 32'd42) begin
            n_bad++;
            $display("FAIL bp_first: got lat=%0d res=%h want lat=33 res=0000002a", lat, res0);
        end
        // Offer a new op while the result is held; it must not be taken
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            funct3      = OP_DIVU;
            op1         = 64'd1000;
            op2         = 64'd3;
            in_valid[0] = (i < 9);
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || res0 !== 32'd42) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d: got ov=%b ir=%b res=%h want ov=1 ir=0 res=0000002a",
                         i, out_valid[0], in_ready[0], res0);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || res0 !== 32'd42) begin
            n_bad++;
            $display("FAIL bp_release: got ov=%b ir=%b res=%h want ov=0 ir=1 res=0000002a",
                     out_valid[0], in_ready[0], res0);
        end
    endtask

    task automatic test_flush();
        // Flush mid-CALC: result keeps the previous value (42)
        issue(0, OP_MUL, 64'd7, M1 - 64'd2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_cmp++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || res0 !== 32'd42) begin
            n_bad++;
            $display("FAIL flush_calc: got ov=%b ir=%b res=%h want ov=0 ir=1 res=0000002a",
                     out_valid[0], in_ready[0], res0);
        end
        repeat (40) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid[0] !== 1'b0 || res0 !== 32'd42) begin
            n_bad++;
            $display("FAIL flush_killed: got ov=%b res=%h want ov=0 res=0000002a", out_valid[0], res0);
        end
        run_op(0, OP_DIVU, 64'd100, 64'd7, 64'd14, 33, "after_flush");

        // Flush while a result is held in DONE
        issue(0, OP_DIV, 64'd5, 64'd0);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_cmp++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || res0 !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL flush_done: got ov=%b ir=%b res=%h want ov=0 ir=1 res=ffffffff",
                     out_valid[0], in_ready[0], res0);
        end

        // Flush beats a simultaneous accept
        @(negedge clk);
        funct3      = OP_REM;
        op1         = 64'd77;
        op2         = 64'd0;
        in_valid[0] = 1'b1;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        flush       = 1'b0;
        n_cmp++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || res0 !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL flush_vs_accept: got ov=%b ir=%b res=%h want ov=0 ir=1 res=ffffffff",
                     out_valid[0], in_ready[0], res0);
        end
    endtask

    task automatic test_reset_mid();
        issue(0, OP_MUL, 64'd6, 64'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || res0 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid: got ov=%b ir=%b res=%h want ov=0 ir=1 res=0",
                     out_valid[0], in_ready[0], res0);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(0, OP_MUL, 64'd7, M1 - 64'd2, 64'hFFFF_FFEB, 33, "after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 4'b0;
        funct3    = 3'b000;
        op1       = 64'h0;
        op2       = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();

        test_basic_ops(0);
        test_boundaries();
        test_fast_path();
        test_backpressure();
        test_flush();
        test_reset_mid();
        for (int k = 1; k < 4; k++) begin
            test_basic_ops(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
